ram_bist_ctrl: RTL and testbench

- Initiator-side built-in self-test controller for the 16x8 synchronous single-port RAM.
- Drives the RAM's we/addr/din pins and checks its registered dout. The RAM has a 1-cycle read latency, and dout holds its value while we=1.
- Runs a 4-phase march: write pattern up, read/compare up, write inverse down, read/compare down.
- Reports pass/fail, the error count and the first failing location to the system controller.

---
 rtl/ram_bist_ctrl.sv | 105 ++++++++++
 tb/tb_ram_bist_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-test BIST controller for a single-port synchronous RAM with 1-cycle read latency.
//   clk, rst_n               clock, async active-low reset
//   start / busy / done      run request, run in progress, run finished (held)
//   pass, err_cnt            result and mismatch count
//   fail_addr/exp/got        first mismatch location, expected and read data
//   mem_we/addr/din, dout    RAM pins (dout is the RAM's registered read data)
module ram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FLUSH, DONE} state_t;
  localparam logic [ADDR_W-1:0] AMAX = '1;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] a, cmp_addr;
  logic [DATA_W-1:0] pat, cmp_exp;
  logic [ADDR_W+1:0] err_nxt;
  logic cmp_vld, mis, go, top, bot, rd, active;
  always_comb begin
    pat = DATA_W'(a) ^ SEED;
    top = a == AMAX;
    bot = a == '0;
    go = start && (state == IDLE || state == DONE);
    rd = state == RD0 || state == RD1;
    active = state inside {WR0, RD0, WR1, RD1};
    // dout holds the data addressed in the previous read cycle, even if we=1 now
    mis = cmp_vld && mem_dout != cmp_exp;
    err_nxt = err_cnt + {{(ADDR_W+1){1'b0}}, mis};
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = go ? WR0 : state;
      WR0:        state_nxt = top ? RD0 : WR0;
      RD0:        state_nxt = top ? WR1 : RD0;
      WR1:        state_nxt = bot ? RD1 : WR1;
      RD1:        state_nxt = bot ? FLUSH : RD1;
      FLUSH:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    busy = active || state == FLUSH;
    mem_we = state == WR0 || state == WR1;
    mem_addr = active ? a : '0;
    mem_din = state == WR0 ? pat : state == WR1 ? ~pat : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      cmp_vld <= 1'b0;
      cmp_exp <= '0;
      cmp_addr <= '0;
      err_cnt <= '0;
      fail_addr <= '0;
      fail_exp <= '0;
      fail_got <= '0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        a <= (state_nxt == WR1 || state_nxt == RD1) ? AMAX : '0;
      else if (state == WR0 || state == RD0)
        a <= a + 1'b1;
      else if (state == WR1 || state == RD1)
        a <= a - 1'b1;
      cmp_vld <= rd;
      cmp_exp <= state == RD0 ? pat : ~pat;
      cmp_addr <= a;
      if (go) begin
        err_cnt <= '0;
        fail_addr <= '0;
        fail_exp <= '0;
        fail_got <= '0;
        done <= 1'b0;
        pass <= 1'b0;
      end else if (mis) begin
        err_cnt <= err_nxt;
        if (err_cnt == '0) begin
          fail_addr <= cmp_addr;
          fail_exp <= cmp_exp;
          fail_got <= mem_dout;
        end
      end
      // FLUSH carries the final RD1 compare, so fold it into pass here
      if (state == FLUSH) begin
        done <= 1'b1;
        pass <= err_nxt == '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: self-checking bench for ram_bist_ctrl with a behavioural 16x8 RAM and injectable faults.
module tb_ram_bist_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, pass, mem_we;
  logic [5:0] err_cnt;
  logic [3:0] fail_addr, mem_addr;
  logic [7:0] fail_exp, fail_got, mem_din, mem_dout;
  logic [7:0] ram [16];
  logic [11:0] wq [$];
  logic [3:0] rq [$];
  int fault = 0;
  int checks = 0, failures = 0;
  int cyc, bc;
  typedef struct {
    int         fault;
    logic [5:0] err;
    logic       pass;
    logic [3:0] faddr;
    logic [7:0] fexp;
    logic [7:0] fgot;
  } vec_t;
  vec_t vec [3];

  always #5 clk = ~clk;

  ram_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // fault 1: bit0 of cell 5 stuck at 0; fault 2: cross-coupled decode of addresses 3 and 9 on write
  function automatic logic [3:0] wmap(input logic [3:0] ad);
    if (fault == 2 && ad == 4'd3) return 4'd9;
    if (fault == 2 && ad == 4'd9) return 4'd3;
    return ad;
  endfunction

  always @(posedge clk) begin
    if (mem_we) ram[wmap(mem_addr)] <= (fault == 1 && mem_addr == 4'd5) ? (mem_din & 8'hFE) : mem_din;
    else mem_dout <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (rst_n && busy) begin
      if (mem_we) wq.push_back({mem_addr, mem_din});
      else rq.push_back(mem_addr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int c, output int b);
    c = 0;
    b = 0;
    while (!done && c < 200) begin
      if (busy) b++;
      tick;
      c++;
    end
  endtask

  initial begin
    vec[0] = '{0, 6'd0, 1'b1, 4'd0, 8'h00, 8'h00};
    vec[1] = '{1, 6'd1, 1'b0, 4'd5, 8'h5F, 8'h5E};
    vec[2] = '{2, 6'd4, 1'b0, 4'd3, 8'hA6, 8'hAC};
    #1;
    chk("rst_async_outs", {busy, done, pass, err_cnt, fail_addr, fail_exp, fail_got, mem_we, mem_addr, mem_din}, 0);
    tick;
    chk("rst_clocked_outs", {busy, done, pass, err_cnt, fail_addr, fail_exp, fail_got, mem_we, mem_addr, mem_din}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_reset;
      fault = vec[i].fault;
      wq.delete();
      rq.delete();
      pulse_start;
      chk($sformatf("v%0d_busy_now", i), busy, 1);
      wait_done(cyc, bc);
      chk($sformatf("v%0d_done_cycle", i), cyc, 65);
      chk($sformatf("v%0d_busy_cycles", i), bc, 65);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_pass", i), pass, vec[i].pass);
      chk($sformatf("v%0d_err_cnt", i), err_cnt, vec[i].err);
      chk($sformatf("v%0d_fail_addr", i), fail_addr, vec[i].faddr);
      chk($sformatf("v%0d_fail_exp", i), fail_exp, vec[i].fexp);
      chk($sformatf("v%0d_fail_got", i), fail_got, vec[i].fgot);
      if (i == 0) begin
        chk("trace_wr_count", wq.size(), 32);
        chk("trace_rd_count", rq.size(), 33);
        if (wq.size() == 32 && rq.size() == 33) begin
          chk("trace_wr0_a0", wq[0], 12'h0A5);
          chk("trace_wr0_a5", wq[5], 12'h5A0);
          chk("trace_wr0_a15", wq[15], 12'hFAA);
          chk("trace_wr1_first", wq[16], 12'hF55);
          chk("trace_wr1_last", wq[31], 12'h05A);
          chk("trace_rd0_first", rq[0], 4'd0);
          chk("trace_rd1_first", rq[16], 4'd15);
          chk("trace_rd1_last", rq[31], 4'd0);
        end
      end
      repeat (3) tick;
      chk($sformatf("v%0d_done_held", i), {done, busy, pass, err_cnt}, {1'b1, 1'b0, vec[i].pass, vec[i].err});
    end
    fault = 0;
    do_reset;
    start = 1'b1;
    tick;
    wait_done(cyc, bc);
    chk("held_first_done", cyc, 65);
    chk("held_done_high", done, 1);
    tick;
    chk("held_restart", {done, busy}, 2'b01);
    wait_done(cyc, bc);
    chk("held_second_done", cyc, 65);
    start = 1'b0;
    chk("held_second_pass", pass, 1);
    do_reset;
    pulse_start;
    cyc = 0;
    while (!done && cyc < 200) begin
      start = (cyc % 20 == 10) || cyc == 64;
      tick;
      cyc++;
    end
    start = 1'b0;
    chk("ignore_done_cycle", cyc, 65);
    repeat (2) tick;
    chk("ignore_no_rerun", {done, busy, pass, err_cnt}, {1'b1, 1'b0, 1'b1, 6'd0});
    do_reset;
    pulse_start;
    repeat (5) tick;
    chk("midwr_we_before", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwr_async_drop", {mem_we, busy, done, mem_addr, mem_din}, 0);
    tick;
    rst_n = 1'b1;
    pulse_start;
    repeat (20) tick;
    chk("midrd_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrd_async_drop", {mem_we, busy, done, err_cnt, mem_addr}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("midrd_stays_idle", {busy, done}, 0);
    pulse_start;
    wait_done(cyc, bc);
    chk("after_rst_done_cycle", cyc, 65);
    chk("after_rst_pass", {pass, err_cnt}, {1'b1, 6'd0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
